// File: rtl/led_indicator.sv
// Multi-channel indicator LED driver: per-channel off / on / blink / one-shot pulse,
// with a shared prescaler tick that is also exported for other timing users.
module led_indicator #(
  parameter int CHANNELS    = 8,
  parameter int TICK_DIV    = 100000,
  parameter int BLINK_TICKS = 250,
  parameter int PULSE_TICKS = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   trig,
  output logic [CHANNELS-1:0]   led,
  output logic                  tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int CW = $clog2(PULSE_TICKS + 1);

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_TICKS);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PULSE = 2'b11
  } mode_e;

  logic [PW-1:0]       preCnt_r;
  logic                tick_r;
  logic [BW-1:0]       blinkCnt_r;
  logic                phase_r;
  logic [CHANNELS-1:0] trigPrev_r;
  logic [CW-1:0]       pulseCnt_r  [CHANNELS];
  logic [CW-1:0]       pulseNext_s [CHANNELS];
  logic [CHANNELS-1:0] edge_s;
  logic [CHANNELS-1:0] ledNext_s;
  logic [CHANNELS-1:0] led_r;

  assign edge_s = trig & ~trigPrev_r;
  assign led    = led_r;
  assign tick   = tick_r;

  // Prescaler, tick strobe and the shared free-running blink phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preCnt_r   <= {PW{1'b0}};
      tick_r     <= 1'b0;
      blinkCnt_r <= {BW{1'b0}};
      phase_r    <= 1'b0;
    end else begin
      if (preCnt_r == PRE_LAST) begin
        preCnt_r <= {PW{1'b0}};
        tick_r   <= 1'b1;
      end else begin
        preCnt_r <= preCnt_r + PW'(1);
        tick_r   <= 1'b0;
      end
      if (tick_r) begin
        if (blinkCnt_r == BLINK_LAST) begin
          blinkCnt_r <= {BW{1'b0}};
          phase_r    <= ~phase_r;
        end else begin
          blinkCnt_r <= blinkCnt_r + BW'(1);
        end
      end
    end
  end

  // Per-channel pulse counter update and LED selection from current state.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      pulseNext_s[i] = pulseCnt_r[i];
      ledNext_s[i]   = 1'b0;
      // Load beats decrement so an edge coinciding with a tick restarts the full length.
      if (mode[2*i +: 2] != MODE_PULSE) begin
        pulseNext_s[i] = {CW{1'b0}};
      end else if (edge_s[i]) begin
        pulseNext_s[i] = PULSE_LOAD;
      end else if (tick_r && (pulseCnt_r[i] != {CW{1'b0}})) begin
        pulseNext_s[i] = pulseCnt_r[i] - CW'(1);
      end else begin
        pulseNext_s[i] = pulseCnt_r[i];
      end
      case (mode[2*i +: 2])
        MODE_OFF:   ledNext_s[i] = 1'b0;
        MODE_ON:    ledNext_s[i] = 1'b1;
        MODE_BLINK: ledNext_s[i] = phase_r;
        MODE_PULSE: ledNext_s[i] = (pulseCnt_r[i] != {CW{1'b0}});
        default:    ledNext_s[i] = 1'b0;
      endcase
    end
  end

  // Channel state registers; trigPrev resets high so a held trigger cannot fire on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trigPrev_r <= {CHANNELS{1'b1}};
      led_r      <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        pulseCnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      trigPrev_r <= trig;
      led_r      <= ledNext_s;
      for (int i = 0; i < CHANNELS; i++) begin
        pulseCnt_r[i] <= pulseNext_s[i];
      end
    end
  end

endmodule

// File: tb/tb_led_indicator.sv
// Randomized bench for led_indicator against a time-based reference model
// (tick, blink phase and pulse lifetime derived from edge counts since reset release).
module tb_led_indicator;

  localparam int CH = 4;
  localparam int TD = 4;
  localparam int BT = 2;
  localparam int PT = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [2*CH-1:0] mode = '0;
  logic [CH-1:0]   trig = '0;
  logic [CH-1:0]   led;
  logic            tick;

  int checks = 0;
  int failures = 0;

  int            n;
  bit            active [CH];
  int            loadT  [CH];
  logic [CH-1:0] trigPrevM;

  led_indicator #(
    .CHANNELS(CH), .TICK_DIV(TD), .BLINK_TICKS(BT), .PULSE_TICKS(PT)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .trig(trig), .led(led), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t (edge %0d)", tag, obs, exp, $time, n);
    end
  endtask

  // Ticks consumed by the design up to and including edge m after release.
  function automatic int tCnt(input int m);
    return (m >= 1) ? (m - 1) / TD : 0;
  endfunction

  function automatic int phaseAt(input int m);
    return (tCnt(m) / BT) % 2;
  endfunction

  function automatic int cntAt(input int i, input int m);
    int d;
    if (!active[i]) return 0;
    d = tCnt(m) - loadT[i];
    return (d >= PT) ? 0 : PT - d;
  endfunction

  task automatic step();
    logic [CH-1:0] expLed;
    logic [1:0]    m;
    @(posedge clk);
    #1;
    n++;
    for (int i = 0; i < CH; i++) begin
      m = mode[2*i +: 2];
      case (m)
        2'b00:   expLed[i] = 1'b0;
        2'b01:   expLed[i] = 1'b1;
        2'b10:   expLed[i] = (phaseAt(n - 1) != 0);
        2'b11:   expLed[i] = (cntAt(i, n - 1) != 0);
        default: expLed[i] = 1'b0;
      endcase
    end
    for (int i = 0; i < CH; i++) begin
      if (mode[2*i +: 2] == 2'b11) begin
        if (trig[i] && !trigPrevM[i]) begin
          active[i] = 1'b1;
          loadT[i]  = tCnt(n);
        end
      end else begin
        active[i] = 1'b0;
      end
    end
    trigPrevM = trig;
    checkVal("led", 32'(expLed), 32'(led));
    checkVal("tick", 32'(tick), 32'((n % TD) == 0));
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkVal("reset_led", 32'(led), 32'h0);
    checkVal("reset_tick", 32'(tick), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    trigPrevM = '1;
    for (int i = 0; i < CH; i++) begin
      active[i] = 1'b0;
      loadT[i]  = 0;
    end
  endtask

  initial begin
    n = 0;
    #2;
    // Trigger on channel 3 held high through reset release in pulse mode must not fire.
    mode = {2'b11, 2'b00, 2'b00, 2'b00};
    trig = 4'b1000;
    doReset();
    repeat (20) step();
    trig[3] = 1'b0;
    step();
    trig[3] = 1'b1;
    step();
    // Pulse on channel 1, then async reset in the middle of it.
    mode[3:2] = 2'b11;
    step();
    trig[1] = 1'b1;
    step();
    trig[1] = 1'b0;
    repeat (5) step();
    checkVal("pulse_lit", 32'(led[1]), 32'h1);
    doReset();
    repeat (10) step();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) doReset();
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 19) == 0) mode[2*i +: 2] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) trig[i] = ~trig[i];
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_indicator.md
Name: led_indicator

Overview:
- Parametrised multi-channel LED driver for the board's indicator LEDs; replaces hard-tied LED outputs.
- Each channel independently selects off, steady on, blink, or one-shot pulse, so the decoder can show key activity, dot/dash feedback and error states.
- Sits between decoder control logic and the top-level LED pins.
- Also exports the shared 1 ms-class tick for other timing users.

Parameters:
- CHANNELS, 8: number of LED outputs, 1..16.
- TICK_DIV, 100000: clocks per tick (1 ms at 100 MHz); must be ≥2.
- BLINK_TICKS, 250: ticks per blink half-period; must be ≥1.
- PULSE_TICKS, 100: pulse length in ticks; must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mode  in  2*CHANNELS  per-channel mode; bits [2i+1:2i] belong to channel i: 00 off, 01 on, 10 blink, 11 pulse
- trig  in  CHANNELS  per-channel pulse trigger, synchronous to clk, rising-edge sensitive
- led  out  CHANNELS  registered LED drive, 1 = lit
- tick  out  1  registered one-cycle strobe, once every TICK_DIV clocks

Behaviour:
- Reset (async, rst=1) clears or sets state as follows:
  - Clears: prescaler, tick, blink counter, blink phase, all pulse counters, led.
  - Sets: trig_q (previous-trig register) to all ones, so a trig held high across reset release does not fire.
- Prescaler:
  - pre counts 0..TICK_DIV-1 and wraps.
  - tick is registered high for exactly the cycle after pre==TICK_DIV-1.
  - First tick appears TICK_DIV clocks after reset release; the period is exactly TICK_DIV.
- Blink generator, shared by all channels:
  - bcnt counts ticks 0..BLINK_TICKS-1.
  - On the tick where bcnt==BLINK_TICKS-1, phase toggles and bcnt returns to 0.
  - phase starts at 0, so blinking channels start dark.
  - Free-running and not re-synchronised on mode change, so all blinking channels are in phase.
- Pulse channel i:
  - edge_i = trig[i] & ~trig_q[i]. trig_q updates every cycle in every mode.
  - Load: if mode_i==11 and edge_i, cnt_i <= PULSE_TICKS.
  - Decrement: else if mode_i==11 and tick and cnt_i!=0, cnt_i <= cnt_i-1.
  - Clear: if mode_i!=11, cnt_i <= 0.
  - Retrigger while counting reloads to PULSE_TICKS (extends the pulse).
  - An edge coinciding with a tick loads; load has priority.
  - Edges in non-pulse modes are ignored and not remembered.
  - cnt width is clog2(PULSE_TICKS+1); no wrap below 0.
- LED output:
  - led[i] registered each cycle from current state: 00→0; 01→1; 10→phase; 11→(cnt_i!=0).
  - Mode change is visible on led one clock later.
  - Pulse: edge sampled at edge k → cnt loaded at k → led=1 after edge k+1.
  - Lit time is PULSE_TICKS ticks, minus less than one tick of prescaler phase jitter. This equals (PULSE_TICKS-1)*TICK_DIV+1 .. PULSE_TICKS*TICK_DIV clocks.
- Reset mid-operation: all channels go dark immediately (async). Pulses in flight are lost. Blink phase restarts dark.
- Channels are fully independent; simultaneous triggers on any subset are all honoured in the same cycle.

Test Plan (TICK_DIV=4, BLINK_TICKS=2, PULSE_TICKS=3, CHANNELS=4):
- Reset, then 20 clocks with mode=0 → led=0000; tick high on clocks 4, 8, 12, 16, 20 after release, one cycle each.
- Channel 0 steady on: mode=01 on channel 0 at cycle 5 → led[0]=1 from cycle 6 and stays; other channels 0. Switch to 00 → led[0]=0 one cycle later.
- Blink: all channels mode=10 from reset → all led bits identical, low for first 8 clocks, then toggling every 8 clocks (high 8, low 8).
- Single pulse: channel 1 in mode=11, trig[1] one-cycle high → led[1] high one cycle after load, lit 9..12 clocks, then 0. A second trig with the channel in mode=00 → led[1] stays 0.
- Retrigger: trig[2] pulses twice 6 clocks apart, with trig held high across one pulse → count reloads on the second edge only. Level-high does not re-fire. led[2] stays continuously high until 3 ticks after the second edge.
- Reset and trig interaction: trig[3] held high through reset release with mode=11 → no pulse. Assert rst mid-pulse on channel 1 → led[1]=0 immediately (async). After release → led=0000 until a new edge arrives.
